mux_n_pipe: RTL and testbench
=============================

// Module: mux_n_pipe
// PURPOSE
//  Parametrised, registered N-input, W-bit selector with valid/ready flow control. Successor
//  to the fixed 8x32 combinational mux used for datapath source selection.
//  - Select and data are captured together, so the output cannot glitch on select changes.
//  - Out-of-range selects are flagged rather than silently zeroed.
//  - Downstream backpressure is absorbed by a one-entry skid, sustaining 1 beat/cycle.
//  - Sits between the operand/forwarding sources and the ALU/writeback stage input register.
// PARAMETERS
//  N      8                number of data inputs (2..32)
//  W      32               data width per input (1..64)
//  SEL_W  $clog2(N) (3)    select width; derived, never overridden
//  ZERO_OOR 1              1: an out-of-range select yields 0; 0: it yields in[0]
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        synchronous active-low reset
//  in_flat    in   N*W      concatenated inputs; input k = in_flat[k*W +: W]
//  in_sel     in   SEL_W    selects the input captured this beat
//  in_valid   in   1        upstream beat present
//  in_ready   out  1        block can accept a beat (registered)
//  out_data   out  W        selected data
//  out_sel    out  SEL_W    select that produced out_data
//  out_err    out  1        in_sel was >= N for this beat
//  out_valid  out  1        out_* holds a valid beat
//  out_ready  in   1        downstream accepts the beat
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge):
//    - out_valid=0, out_data=0, out_sel=0, out_err=0, in_ready=1; skid cleared.
//    - A beat in flight is dropped; reset wins over any simultaneous handshake.
//  - Handshake: transfer on a clk edge where valid&&ready; AXI-style.
//    - Once out_valid=1, out_data, out_sel and out_err hold stable until out_ready=1.
//    - out_valid is never retracted before acceptance.
//  - Select: idx=in_sel.
//    - idx<N: data=input idx, err=0.
//    - idx>=N (only possible when N is not a power of 2): err=1; data=0 if ZERO_OOR, else input 0.
//  - Latency: 1 cycle from input acceptance to out_valid. Throughput: 1 beat/cycle with out_ready=1.
//  - FSM (state register; in_ready = state!=FULL):
//    - EMPTY: accept -> ONE (main reg loaded).
//    - ONE:
//      - accept && out_ready -> ONE (main reloaded).
//      - accept && !out_ready -> FULL (beat goes to skid).
//      - !accept && out_ready -> EMPTY.
//      - else stay.
//    - FULL: out_ready -> ONE (skid moves to main, same edge); else stay. No accept in FULL.
//  - Boundaries:
//    - Simultaneous accept and drain in ONE keeps ONE with no bubble.
//    - FULL with out_ready=1 returns in_ready=1 the next cycle.
//    - in_valid is ignored when in_ready=0; data is not sampled then.
//  - No $display and no # delays in RTL.
// STRUCTURE
//  - Shared package mips_pkg:
//    - state localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
//    - clog2 helper.
//  - Sub-module mux_n_comb: purely combinational N:1 W-bit select with range check.
//    - Outputs data, err; no storage.
//  - Top: mux_n_comb feeding the skid/main registers and the FSM.
// TESTING
//  - Reset: after rst_n=0 for 2 cycles -> out_valid=0, out_data=0, in_ready=1.
//  - Streaming, out_ready=1: sel 0..7 with in k=32'hA0+k -> out_data A0..A7, each 1 cycle later, no bubbles.
//  - Backpressure: hold out_ready=0, send 2 beats (sel 3, sel 5) -> in_ready=0 after 2nd;
//    out_data=A3 stable; raise out_ready -> A3 then A5, then in_ready=1.
//  - N=6: sel=7 -> out_err=1, out_data=0 with ZERO_OOR=1; out_data=in[0] with ZERO_OOR=0.
//  - Mid-operation reset in FULL -> next cycle EMPTY, out_valid=0, both beats lost, in_ready=1.
//  - Random valid/ready (W=16, N=5): scoreboard checks order, data, sel, err; no drop or dup.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared state encoding and width helper for the registered N:1 selector.
package mips_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Combinational N:1 W-bit select with out-of-range detection; holds no state.
module mux_n_comb
   import mips_pkg::*;
#(
   parameter int N          = 8,
   parameter int W          = 32,
   parameter bit ZERO_OOR   = 1'b1,
   localparam int SEL_W     = clog2(N)
) (
   input  logic [N*W-1:0]   in_flat_i,
   input  logic [SEL_W-1:0] sel_i,
   output logic [W-1:0]     data_o,
   output logic             err_o
);

   // Start from the out-of-range result; any in-range match overrides it.
   always_comb begin
      data_o = ZERO_OOR ? '0 : in_flat_i[W-1:0];
      err_o  = 1'b1;
      for (int k = 0; k < N; k++) begin
         if (int'(sel_i) == k) begin
            data_o = in_flat_i[k*W +: W];
            err_o  = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mux_n_pipe.sv
// Registered N:1 selector with valid/ready flow control and a one-entry skid buffer.
module mux_n_pipe
   import mips_pkg::*;
#(
   parameter int N          = 8,
   parameter int W          = 32,
   parameter bit ZERO_OOR   = 1'b1,
   localparam int SEL_W     = clog2(N)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N*W-1:0]   in_flat,
   input  logic [SEL_W-1:0] in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [W-1:0]     out_data,
   output logic [SEL_W-1:0] out_sel,
   output logic             out_err,
   output logic             out_valid,
   input  logic             out_ready,
   output state_e           dbg_state
);

   // Handshake: a beat moves on a rising clk edge where valid && ready are both high.
   // The producer never drops valid before that edge and holds its payload stable meanwhile.

   state_e             state_q, state_d;
   logic [W-1:0]       data_q, data_d, skid_data_q, skid_data_d;
   logic [SEL_W-1:0]   sel_q, sel_d, skid_sel_q, skid_sel_d;
   logic               err_q, err_d, skid_err_q, skid_err_d;
   logic [W-1:0]       mux_data;
   logic               mux_err;
   logic               accept;

   mux_n_comb #(
      .N        (N),
      .W        (W),
      .ZERO_OOR (ZERO_OOR)
   ) u_comb (
      .in_flat_i (in_flat),
      .sel_i     (in_sel),
      .data_o    (mux_data),
      .err_o     (mux_err)
   );

   assign in_ready  = (state_q != ST_FULL);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state_q != ST_EMPTY);
   assign out_data  = data_q;
   assign out_sel   = sel_q;
   assign out_err   = err_q;
   assign dbg_state = state_q;

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      sel_d       = sel_q;
      err_d       = err_q;
      skid_data_d = skid_data_q;
      skid_sel_d  = skid_sel_q;
      skid_err_d  = skid_err_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               data_d  = mux_data;
               sel_d   = in_sel;
               err_d   = mux_err;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && out_ready) begin
               data_d = mux_data;
               sel_d  = in_sel;
               err_d  = mux_err;
            end else if (accept) begin
               // Main register is stalled, so the new beat parks in the skid.
               skid_data_d = mux_data;
               skid_sel_d  = in_sel;
               skid_err_d  = mux_err;
               state_d     = ST_FULL;
            end else if (out_ready) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (out_ready) begin
               data_d  = skid_data_q;
               sel_d   = skid_sel_q;
               err_d   = skid_err_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         data_q      <= '0;
         sel_q       <= '0;
         err_q       <= 1'b0;
         skid_data_q <= '0;
         skid_sel_q  <= '0;
         skid_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         sel_q       <= sel_d;
         err_q       <= err_d;
         skid_data_q <= skid_data_d;
         skid_sel_q  <= skid_sel_d;
         skid_err_q  <= skid_err_d;
      end
   end

endmodule

// File: tb/tb_mux_n_pipe.sv
// Self-checking bench for mux_n_pipe: directed 8x32 and 6x32 cases plus a randomised 5x16 stream.
module tb_mux_n_pipe;
   import mips_pkg::*;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- instance A: N=8, W=32 ----------------
   logic [255:0] a_in_flat;
   logic [2:0]   a_in_sel, a_out_sel;
   logic         a_in_valid, a_in_ready, a_out_err, a_out_valid, a_out_ready;
   logic [31:0]  a_out_data;
   state_e       a_dbg_state;
   logic [35:0]  a_q[$];

   mux_n_pipe #(.N(8), .W(32), .ZERO_OOR(1'b1)) u_a (
      .clk(clk), .rst_n(rst_n), .in_flat(a_in_flat), .in_sel(a_in_sel),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .out_data(a_out_data),
      .out_sel(a_out_sel), .out_err(a_out_err), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .dbg_state(a_dbg_state)
   );

   // ---------------- instances B/C: N=6, W=32, ZERO_OOR 1 and 0 ----------------
   logic [191:0] bc_in_flat;
   logic [2:0]   bc_in_sel, b_out_sel, c_out_sel;
   logic         bc_in_valid, bc_out_ready;
   logic         b_in_ready, b_out_err, b_out_valid;
   logic         c_in_ready, c_out_err, c_out_valid;
   logic [31:0]  b_out_data, c_out_data;
   state_e       b_dbg_state, c_dbg_state;

   mux_n_pipe #(.N(6), .W(32), .ZERO_OOR(1'b1)) u_b (
      .clk(clk), .rst_n(rst_n), .in_flat(bc_in_flat), .in_sel(bc_in_sel),
      .in_valid(bc_in_valid), .in_ready(b_in_ready), .out_data(b_out_data),
      .out_sel(b_out_sel), .out_err(b_out_err), .out_valid(b_out_valid),
      .out_ready(bc_out_ready), .dbg_state(b_dbg_state)
   );

   mux_n_pipe #(.N(6), .W(32), .ZERO_OOR(1'b0)) u_c (
      .clk(clk), .rst_n(rst_n), .in_flat(bc_in_flat), .in_sel(bc_in_sel),
      .in_valid(bc_in_valid), .in_ready(c_in_ready), .out_data(c_out_data),
      .out_sel(c_out_sel), .out_err(c_out_err), .out_valid(c_out_valid),
      .out_ready(bc_out_ready), .dbg_state(c_dbg_state)
   );

   // ---------------- instance D: N=5, W=16, random traffic ----------------
   logic [79:0]  d_in_flat;
   logic [2:0]   d_in_sel, d_out_sel;
   logic         d_in_valid, d_in_ready, d_out_err, d_out_valid, d_out_ready;
   logic [15:0]  d_out_data;
   state_e       d_dbg_state;
   logic [19:0]  d_q[$];
   logic [19:0]  d_held;
   logic         d_hold;
   int           d_pushed, d_popped;

   mux_n_pipe #(.N(5), .W(16), .ZERO_OOR(1'b1)) u_d (
      .clk(clk), .rst_n(rst_n), .in_flat(d_in_flat), .in_sel(d_in_sel),
      .in_valid(d_in_valid), .in_ready(d_in_ready), .out_data(d_out_data),
      .out_sel(d_out_sel), .out_err(d_out_err), .out_valid(d_out_valid),
      .out_ready(d_out_ready), .dbg_state(d_dbg_state)
   );

   // ---------------- check helper ----------------
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [35:0] a_model(input logic [2:0] sel);
      return {1'b0, sel, 32'hA0 + 32'(sel)};
   endfunction

   function automatic logic [19:0] d_model(input logic [2:0] sel);
      logic [15:0] data;
      if (sel < 3'd5) return {1'b0, sel, d_in_flat[int'(sel)*16 +: 16]};
      data = 16'h0;
      return {1'b1, sel, data};
   endfunction

   // ---------------- scoreboard monitors (sample on falling edge) ----------------
   initial begin
      logic [35:0] a_exp;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            if (a_out_valid && a_out_ready) begin
               chk("a_sb_nonempty", 64'(a_q.size() != 0), 64'd1);
               if (a_q.size() != 0) begin
                  a_exp = a_q.pop_front();
                  chk("a_sb_beat", {a_out_err, a_out_sel, a_out_data}, a_exp);
               end
            end
            if (a_in_valid && a_in_ready) a_q.push_back(a_model(a_in_sel));
         end
      end
   end

   initial begin
      logic [19:0] d_exp;
      d_hold = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            d_hold = 1'b0;
         end else begin
            if (d_hold)
               chk("d_stable", {d_out_valid, d_out_err, d_out_sel, d_out_data}, {1'b1, d_held});
            if (d_out_valid && d_out_ready) begin
               chk("d_sb_nonempty", 64'(d_q.size() != 0), 64'd1);
               if (d_q.size() != 0) begin
                  d_exp = d_q.pop_front();
                  d_popped++;
                  chk("d_sb_beat", {d_out_err, d_out_sel, d_out_data}, d_exp);
               end
            end
            d_hold = d_out_valid && !d_out_ready;
            d_held = {d_out_err, d_out_sel, d_out_data};
            if (d_in_valid && d_in_ready) begin
               d_q.push_back(d_model(d_in_sel));
               d_pushed++;
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   initial begin
      n_checks = 0; n_errors = 0; d_pushed = 0; d_popped = 0;
      rst_n = 1'b0;
      for (int k = 0; k < 8; k++) a_in_flat[k*32 +: 32] = 32'hA0 + k;
      for (int k = 0; k < 6; k++) bc_in_flat[k*32 +: 32] = 32'hB0 + k;
      for (int k = 0; k < 5; k++) d_in_flat[k*16 +: 16] = 16'($urandom);
      a_in_sel = 3'd0; a_in_valid = 1'b0; a_out_ready = 1'b0;
      bc_in_sel = 3'd0; bc_in_valid = 1'b0; bc_out_ready = 1'b0;
      d_in_sel = 3'd0; d_in_valid = 1'b0; d_out_ready = 1'b0;

      // Reset
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", a_out_valid, 1'b0);
      chk("rst_out_data", a_out_data, 32'h0);
      chk("rst_out_sel", a_out_sel, 3'd0);
      chk("rst_out_err", a_out_err, 1'b0);
      chk("rst_in_ready", a_in_ready, 1'b1);
      chk("rst_state", a_dbg_state, ST_EMPTY);
      chk("rst_d_out_valid", d_out_valid, 1'b0);
      rst_n = 1'b1;

      // Streaming with out_ready held high: one beat per cycle, no bubbles
      @(posedge clk); #1;
      a_in_valid = 1'b1; a_in_sel = 3'd0; a_out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (k < 7) a_in_sel = 3'(k + 1);
         else a_in_valid = 1'b0;
         @(negedge clk);
         chk("stream_valid", a_out_valid, 1'b1);
         chk("stream_data", a_out_data, 32'hA0 + k);
         chk("stream_in_ready", a_in_ready, 1'b1);
      end
      @(posedge clk); #1;
      @(negedge clk);
      chk("stream_drained", a_out_valid, 1'b0);

      // Backpressure: two beats into a stalled output fill main + skid
      @(posedge clk); #1;
      a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_sel = 3'd3;
      @(posedge clk); #1;
      a_in_sel = 3'd5;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      @(negedge clk);
      chk("bp_in_ready", a_in_ready, 1'b0);
      chk("bp_state", a_dbg_state, ST_FULL);
      chk("bp_data", a_out_data, 32'hA3);
      chk("bp_sel", a_out_sel, 3'd3);
      // in_valid while full must be ignored
      @(posedge clk); #1;
      a_in_valid = 1'b1; a_in_sel = 3'd7;
      @(negedge clk);
      chk("bp_hold_data", a_out_data, 32'hA3);
      chk("bp_hold_in_ready", a_in_ready, 1'b0);
      @(posedge clk); #1;
      a_in_valid = 1'b0; a_out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_data0", a_out_data, 32'hA3);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_release_data1", a_out_data, 32'hA5);
      chk("bp_release_valid", a_out_valid, 1'b1);
      chk("bp_release_in_ready", a_in_ready, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_empty", a_out_valid, 1'b0);
      chk("bp_empty_q", 64'(a_q.size()), 64'd0);

      // Out-of-range select on N=6 with both ZERO_OOR settings
      @(posedge clk); #1;
      bc_out_ready = 1'b1; bc_in_valid = 1'b1; bc_in_sel = 3'd4;
      @(posedge clk); #1;
      bc_in_sel = 3'd6;
      @(negedge clk);
      chk("n6_b_data4", b_out_data, 32'hB4);
      chk("n6_b_err4", b_out_err, 1'b0);
      chk("n6_c_data4", c_out_data, 32'hB4);
      @(posedge clk); #1;
      bc_in_sel = 3'd7;
      @(negedge clk);
      chk("n6_b_err6", {b_out_err, b_out_sel, b_out_data}, {1'b1, 3'd6, 32'h0});
      chk("n6_c_err6", {c_out_err, c_out_sel, c_out_data}, {1'b1, 3'd6, 32'hB0});
      @(posedge clk); #1;
      bc_in_valid = 1'b0;
      @(negedge clk);
      chk("n6_b_err7", {b_out_valid, b_out_err, b_out_sel, b_out_data}, {1'b1, 1'b1, 3'd7, 32'h0});
      chk("n6_c_err7", {c_out_valid, c_out_err, c_out_sel, c_out_data}, {1'b1, 1'b1, 3'd7, 32'hB0});

      // Mid-operation reset while full: both beats are lost
      @(posedge clk); #1;
      a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_sel = 3'd1;
      @(posedge clk); #1;
      a_in_sel = 3'd2;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      @(negedge clk);
      chk("mrst_full", a_dbg_state, ST_FULL);
      @(posedge clk); #1;
      rst_n = 1'b0; a_out_ready = 1'b1; a_in_valid = 1'b1; a_in_sel = 3'd4;
      @(posedge clk); #1;
      a_q.delete();
      rst_n = 1'b1; a_in_valid = 1'b0;
      @(negedge clk);
      chk("mrst_state", a_dbg_state, ST_EMPTY);
      chk("mrst_out_valid", a_out_valid, 1'b0);
      chk("mrst_in_ready", a_in_ready, 1'b1);
      chk("mrst_out_data", a_out_data, 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mrst_stays_empty", a_out_valid, 1'b0);

      // Random valid/ready traffic on N=5, W=16
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         d_in_valid  = ($urandom_range(0, 3) != 0);
         d_in_sel    = 3'($urandom_range(0, 7));
         d_out_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      d_in_valid = 1'b0; d_out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (d_q.size() == 0 && !d_out_valid) break;
      end
      @(negedge clk);
      chk("d_drain_q", 64'(d_q.size()), 64'd0);
      chk("d_drain_valid", d_out_valid, 1'b0);
      chk("d_count", 64'(d_popped), 64'(d_pushed));
      chk("d_traffic_seen", 64'(d_pushed > 50), 64'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
